// File: rtl/demux_pkg.sv
// Shared definitions for the 1:8 capture demultiplexer.
//   state_e    : frame FSM encoding (IDLE / FILL / FULL)
//   OUT_W_DEF  : default number of output slots
//   SEL_W_DEF  : default select / pointer width
//   ALL_FILLED : fill map value that marks a complete frame
package demux_pkg;

  localparam int         OUT_W_DEF  = 8;
  localparam int         SEL_W_DEF  = 3;
  localparam logic [7:0] ALL_FILLED = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector for a level input (button / strobe).
//   clk    : clock
//   rst    : synchronous active-high reset (clears the history flop)
//   in_i   : level input
//   rise_o : one-cycle pulse when in_i is high and was low last cycle
module edge_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic rise_o
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in_i;
  end

  assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/demux_1_8_capture.sv
// Registered 1:8 demultiplexer: steers din into one of OUT_W held led bits
// on each rising edge of wr, either at slot sel (mode=0) or at an
// auto-incrementing internal pointer (mode=1). Tracks written slots and
// flags a complete frame; once FULL, writes are ignored until clr / rst.
//
// Optional build macro DEMUX_SYNC_EN: din, sel, wr, mode and clr each pass
// through a 2-flop synchronizer before use (input-to-led latency 3 cycles).
//
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   din        : data bit to steer
//   sel        : target slot in addressed mode
//   wr         : write strobe, acts on its rising edge only
//   mode       : 0 = addressed (sel), 1 = sequential (ptr)
//   clr        : synchronous clear of data, fill map, pointer and FSM
//   led        : captured bits
//   ptr        : sequential pointer
//   filled     : per-slot written-since-clear map
//   full       : all slots filled
//   frame_done : one-cycle pulse on entry to FULL
module demux_1_8_capture
  import demux_pkg::*;
#(
  parameter int               OUT_W     = OUT_W_DEF,
  parameter int               SEL_W     = SEL_W_DEF,
  parameter logic [OUT_W-1:0] RESET_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  input  logic             wr,
  input  logic             mode,
  input  logic             clr,
  output logic [OUT_W-1:0] led,
  output logic [SEL_W-1:0] ptr,
  output logic [OUT_W-1:0] filled,
  output logic             full,
  output logic             frame_done
);

  // Inputs as seen by the core (synchronized or direct)
  logic             din_s;
  logic [SEL_W-1:0] sel_s;
  logic             wr_s;
  logic             mode_s;
  logic             clr_s;

`ifdef DEMUX_SYNC_EN
  localparam int SYW = SEL_W + 4;

  logic [SYW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {din, sel, wr, mode, clr};
      sync2_q <= sync1_q;
    end
  end

  assign {din_s, sel_s, wr_s, mode_s, clr_s} = sync2_q;
`else
  assign din_s  = din;
  assign sel_s  = sel;
  assign wr_s   = wr;
  assign mode_s = mode;
  assign clr_s  = clr;
`endif

  logic wr_rise;

  edge_rise_det u_wr_edge (
    .clk    (clk),
    .rst    (rst),
    .in_i   (wr_s),
    .rise_o (wr_rise)
  );

  state_e           state_q;
  logic [OUT_W-1:0] led_q, led_d;
  logic [OUT_W-1:0] filled_q, filled_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             frame_done_q;

  logic [SEL_W-1:0] tgt;
  logic [OUT_W-1:0] tgt_mask;
  logic             wr_acc;
  logic             done_d;

  // A clear in the same cycle drops the write; a FULL frame is frozen.
  always_comb begin
    tgt      = mode_s ? ptr_q : sel_s;
    tgt_mask = {{(OUT_W-1){1'b0}}, 1'b1} << tgt;
    wr_acc   = wr_rise & ~clr_s & (state_q != FULL);

    led_d    = led_q;
    filled_d = filled_q;
    ptr_d    = ptr_q;
    if (wr_acc) begin
      led_d    = (led_q & ~tgt_mask) | (din_s ? tgt_mask : '0);
      filled_d = filled_q | tgt_mask;
      if (mode_s) ptr_d = ptr_q + 1'b1;  // natural wrap 7 -> 0
    end

    done_d = wr_acc && (filled_d == ALL_FILLED[OUT_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      state_q      <= IDLE;
      led_q        <= RESET_VAL;
      filled_q     <= '0;
      ptr_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      led_q        <= led_d;
      filled_q     <= filled_d;
      ptr_q        <= ptr_d;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: if (wr_acc) begin
          state_q      <= done_d ? FULL : FILL;
          frame_done_q <= done_d;
        end
        FILL: if (done_d) begin
          state_q      <= FULL;
          frame_done_q <= 1'b1;
        end
        FULL:    state_q <= FULL;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign led        = led_q;
  assign ptr        = ptr_q;
  assign filled     = filled_q;
  assign full       = (state_q == FULL);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_1_8_capture.sv
module tb_demux_1_8_capture;

`ifdef DEMUX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, din, wr, mode, clr;
  logic [2:0] sel;
  logic [7:0] led, filled;
  logic [2:0] ptr;
  logic       full, frame_done;

  int cmp = 0;
  int errs = 0;
  int fd_cnt = 0;

  demux_1_8_capture dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .sel        (sel),
    .wr         (wr),
    .mode       (mode),
    .clr        (clr),
    .led        (led),
    .ptr        (ptr),
    .filled     (filled),
    .full       (full),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1; wr = 1'b0; clr = 1'b0; din = 1'b0; sel = 3'd0; mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle wr pulse; waits until the write is visible and counts
  // frame_done pulses seen along the way.
  task automatic do_write(input logic d, input logic [2:0] s, input logic m);
    din = d; sel = s; mode = m; wr = 1'b1;
    @(negedge clk);
    if (frame_done) fd_cnt++;
    wr = 1'b0;
    repeat (LAT) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; clr = 1'b0; din = 1'b1; sel = 3'd0; mode = 1'b0;
    repeat (2) @(negedge clk);
    cmp++; if (led !== 8'h00) begin errs++; $display("FAIL reset_led: got %h exp 00", led); end
    cmp++; if (ptr !== 3'd0) begin errs++; $display("FAIL reset_ptr: got %0d exp 0", ptr); end
    cmp++; if (filled !== 8'h00) begin errs++; $display("FAIL reset_filled: got %h exp 00", filled); end
    cmp++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full: got %b exp 0", full); end
    cmp++; if (frame_done !== 1'b0) begin errs++; $display("FAIL reset_frame_done: got %b exp 0", frame_done); end
    rst = 1'b0; din = 1'b0;
  endtask

  task automatic test_held_strobe();
    apply_reset();
    mode = 1'b0; sel = 3'd5; din = 1'b1; wr = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    cmp++; if (led !== 8'h00) begin errs++; $display("FAIL held_before_latency: got %h exp 00", led); end
    @(negedge clk);
    cmp++; if (led !== 8'h20) begin errs++; $display("FAIL held_first_write: got %h exp 20", led); end
    // A retrigger while held would now clear bit 5.
    din = 1'b0;
    repeat (9) @(negedge clk);
    wr = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    cmp++; if (led !== 8'h20) begin errs++; $display("FAIL held_single_write: got %h exp 20", led); end
    cmp++; if (filled !== 8'h20) begin errs++; $display("FAIL held_filled: got %h exp 20", filled); end
    cmp++; if (ptr !== 3'd0) begin errs++; $display("FAIL held_ptr: got %0d exp 0", ptr); end
    cmp++; if (full !== 1'b0) begin errs++; $display("FAIL held_full: got %b exp 0", full); end
  endtask

  task automatic test_seq_fill();
    logic [7:0] pat;
    pat = 8'b0100_1101;  // din sequence 1,0,1,1,0,0,1,0 into slots 0..7
    apply_reset();
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      do_write(pat[i], 3'd0, 1'b1);
      if (i == 2) begin
        cmp++; if (ptr !== 3'd3) begin errs++; $display("FAIL seq_mid_ptr: got %0d exp 3", ptr); end
        cmp++; if (full !== 1'b0) begin errs++; $display("FAIL seq_mid_full: got %b exp 0", full); end
      end
    end
    cmp++; if (led !== 8'h4D) begin errs++; $display("FAIL seq_led: got %h exp 4d", led); end
    cmp++; if (ptr !== 3'd0) begin errs++; $display("FAIL seq_ptr_wrap: got %0d exp 0", ptr); end
    cmp++; if (filled !== 8'hFF) begin errs++; $display("FAIL seq_filled: got %h exp ff", filled); end
    cmp++; if (full !== 1'b1) begin errs++; $display("FAIL seq_full: got %b exp 1", full); end
    cmp++; if (fd_cnt !== 1) begin errs++; $display("FAIL seq_frame_done_count: got %0d exp 1", fd_cnt); end
    @(negedge clk);
    cmp++; if (frame_done !== 1'b0) begin errs++; $display("FAIL seq_frame_done_idle: got %b exp 0", frame_done); end
    // Writes in FULL are ignored, in both modes.
    fd_cnt = 0;
    do_write(1'b1, 3'd0, 1'b1);
    do_write(1'b1, 3'd7, 1'b0);
    cmp++; if (led !== 8'h4D) begin errs++; $display("FAIL full_ignore_led: got %h exp 4d", led); end
    cmp++; if (ptr !== 3'd0) begin errs++; $display("FAIL full_ignore_ptr: got %0d exp 0", ptr); end
    cmp++; if (full !== 1'b1) begin errs++; $display("FAIL full_hold: got %b exp 1", full); end
    cmp++; if (fd_cnt !== 0) begin errs++; $display("FAIL full_no_refire: got %0d exp 0", fd_cnt); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    cmp++; if (led !== 8'h00) begin errs++; $display("FAIL clr_full_led: got %h exp 00", led); end
    cmp++; if (filled !== 8'h00) begin errs++; $display("FAIL clr_full_filled: got %h exp 00", filled); end
    cmp++; if (full !== 1'b0) begin errs++; $display("FAIL clr_full_state: got %b exp 0", full); end
  endtask

  task automatic test_overwrite_mode();
    apply_reset();
    do_write(1'b1, 3'd0, 1'b1);
    do_write(1'b1, 3'd0, 1'b1);
    cmp++; if (ptr !== 3'd2) begin errs++; $display("FAIL ovw_ptr2: got %0d exp 2", ptr); end
    cmp++; if (led !== 8'h03) begin errs++; $display("FAIL ovw_led_seq: got %h exp 03", led); end
    do_write(1'b0, 3'd0, 1'b0);
    cmp++; if (led !== 8'h02) begin errs++; $display("FAIL ovw_led_addr: got %h exp 02", led); end
    cmp++; if (filled !== 8'h03) begin errs++; $display("FAIL ovw_filled: got %h exp 03", filled); end
    cmp++; if (ptr !== 3'd2) begin errs++; $display("FAIL ovw_ptr_hold: got %0d exp 2", ptr); end
    do_write(1'b1, 3'd6, 1'b1);
    cmp++; if (led !== 8'h06) begin errs++; $display("FAIL ovw_led_back: got %h exp 06", led); end
    cmp++; if (ptr !== 3'd3) begin errs++; $display("FAIL ovw_ptr3: got %0d exp 3", ptr); end
    cmp++; if (filled !== 8'h07) begin errs++; $display("FAIL ovw_filled_back: got %h exp 07", filled); end
  endtask

  task automatic test_clr_collision();
    // Entered in FILL from the previous test.
    mode = 1'b0; sel = 3'd3; din = 1'b1; wr = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);  // wr still held: must not retrigger
    wr = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    cmp++; if (led !== 8'h00) begin errs++; $display("FAIL coll_led: got %h exp 00", led); end
    cmp++; if (filled !== 8'h00) begin errs++; $display("FAIL coll_filled: got %h exp 00", filled); end
    cmp++; if (ptr !== 3'd0) begin errs++; $display("FAIL coll_ptr: got %0d exp 0", ptr); end
    cmp++; if (full !== 1'b0) begin errs++; $display("FAIL coll_full: got %b exp 0", full); end
    do_write(1'b1, 3'd3, 1'b0);
    cmp++; if (led !== 8'h08) begin errs++; $display("FAIL coll_after_write: got %h exp 08", led); end
  endtask

  task automatic test_rst_wr_held();
    rst = 1'b1; clr = 1'b0; mode = 1'b0; sel = 3'd7; din = 1'b1; wr = 1'b1;
    repeat (2) @(negedge clk);
    cmp++; if (led !== 8'h00) begin errs++; $display("FAIL rst_held_in_reset: got %h exp 00", led); end
    rst = 1'b0;
    repeat (LAT) @(negedge clk);
    cmp++; if (led !== 8'h80) begin errs++; $display("FAIL rst_held_write: got %h exp 80", led); end
    cmp++; if (filled !== 8'h80) begin errs++; $display("FAIL rst_held_filled: got %h exp 80", filled); end
    wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_held_strobe();
    test_seq_fill();
    test_overwrite_mode();
    test_clr_collision();
    test_rst_wr_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
